// File: rtl/memory_cycle_pkg.sv
// Shared RISC-V pipeline constants and the Memory->Writeback stage bundle.
package memory_cycle_pkg;

    localparam int DMEM_DEPTH_DEFAULT = 1024;
    localparam int DATA_W             = 32;
    localparam int REG_IDX_W          = 5;

    typedef struct packed {
        logic                 regWrite;
        logic                 resultSrc;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    pcPlus4;
        logic [DATA_W-1:0]    aluResult;
        logic [DATA_W-1:0]    readData;
    } wb_stage_t;

endpackage

// File: rtl/memory_cycle_data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
import memory_cycle_pkg::*;

module data_memory #(
    parameter int DEPTH  = DMEM_DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch on purpose; clearing a RAM on reset
    // prevents block-RAM inference. Reset only blocks the write strobe.
    always_ff @(posedge clk) begin
        if (WE && rst) begin
            mem[A] <= WD;
        end
    end

    assign RD = mem[A];

endmodule

// File: rtl/memory_cycle.sv
// Memory pipeline stage: data memory access plus the M->W pipeline register.
import memory_cycle_pkg::*;

module memory_cycle #(
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RegWriteM,
    input  logic                 MemWriteM,
    input  logic                 ResultSrcM,
    input  logic [REG_IDX_W-1:0] RD_M,
    input  logic [DATA_W-1:0]    PCPlus4M,
    input  logic [DATA_W-1:0]    WriteDataM,
    input  logic [DATA_W-1:0]    ALU_ResultM,
    output logic                 RegWriteW,
    output logic                 ResultSrcW,
    output logic [REG_IDX_W-1:0] RD_W,
    output logic [DATA_W-1:0]    PCPlus4W,
    output logic [DATA_W-1:0]    ALU_ResultW,
    output logic [DATA_W-1:0]    ReadDataW
);

    localparam int ADDR_W = $clog2(DMEM_DEPTH);

    logic [ADDR_W-1:0] wordIndex;
    logic [DATA_W-1:0] readData;
    wb_stage_t         wStage;

    // Byte offset and out-of-range upper bits are dropped, so accesses wrap.
    assign wordIndex = ALU_ResultM[ADDR_W+1:2];

    data_memory #(
        .DEPTH (DMEM_DEPTH),
        .ADDR_W(ADDR_W)
    ) u_data_memory (
        .clk(clk),
        .rst(rst),
        .WE (MemWriteM),
        .A  (wordIndex),
        .WD (WriteDataM),
        .RD (readData)
    );

    // NOTE: non-blocking assignments here so every W field samples the values
    // present before this edge; readData is therefore the pre-store contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wStage <= '0;
        end else begin
            wStage.regWrite  <= RegWriteM;
            wStage.resultSrc <= ResultSrcM;
            wStage.rd        <= RD_M;
            wStage.pcPlus4   <= PCPlus4M;
            wStage.aluResult <= ALU_ResultM;
            wStage.readData  <= readData;
        end
    end

    assign RegWriteW   = wStage.regWrite;
    assign ResultSrcW  = wStage.resultSrc;
    assign RD_W        = wStage.rd;
    assign PCPlus4W    = wStage.pcPlus4;
    assign ALU_ResultW = wStage.aluResult;
    assign ReadDataW   = wStage.readData;

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle against a word-array reference model.
module tb_memory_cycle;

    localparam int TB_DEPTH = 64;

    typedef struct {
        logic        regWrite;
        logic        resultSrc;
        logic [4:0]  rd;
        logic [31:0] pcPlus4;
        logic [31:0] aluResult;
        logic [31:0] readData;
        bit          readKnown;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    int checks   = 0;
    int failures = 0;

    expect_t     sbq[$];
    logic [31:0] modelMem [TB_DEPTH];
    bit          modelKnown [TB_DEPTH];

    memory_cycle #(.DMEM_DEPTH(TB_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RD_M       (RD_M),
        .PCPlus4M   (PCPlus4M),
        .WriteDataM (WriteDataM),
        .ALU_ResultM(ALU_ResultM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RD_W       (RD_W),
        .PCPlus4W   (PCPlus4W),
        .ALU_ResultW(ALU_ResultW),
        .ReadDataW  (ReadDataW)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wordOf(input logic [31:0] addr);
        return int'((addr >> 2) % TB_DEPTH);
    endfunction

    // Issue one Memory-stage cycle; the model predicts the W outputs after the next edge.
    task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu);
        expect_t e;
        int      w;
        @(negedge clk);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        RD_M        = rd;
        PCPlus4M    = pc;
        WriteDataM  = wd;
        ALU_ResultM = alu;
        w           = wordOf(alu);
        e.regWrite  = rw;
        e.resultSrc = rs;
        e.rd        = rd;
        e.pcPlus4   = pc;
        e.aluResult = alu;
        e.readData  = modelMem[w];
        e.readKnown = modelKnown[w];
        sbq.push_back(e);
        if (mw) begin
            modelMem[w]   = wd;
            modelKnown[w] = 1'b1;
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, data, addr);
    endtask

    task automatic load(input logic [31:0] addr);
        drive(1'b1, 1'b0, 1'b1, 5'd1, 32'h0, 32'h0, addr);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_RegWriteW"},   {31'h0, RegWriteW},  32'h0);
        check({tag, "_ResultSrcW"},  {31'h0, ResultSrcW}, 32'h0);
        check({tag, "_RD_W"},        {27'h0, RD_W},       32'h0);
        check({tag, "_PCPlus4W"},    PCPlus4W,            32'h0);
        check({tag, "_ALU_ResultW"}, ALU_ResultW,         32'h0);
        check({tag, "_ReadDataW"},   ReadDataW,           32'h0);
    endtask

    // Monitor: the W register updates on every edge, so one expectation per edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("RegWriteW",   {31'h0, RegWriteW},  {31'h0, e.regWrite});
                check("ResultSrcW",  {31'h0, ResultSrcW}, {31'h0, e.resultSrc});
                check("RD_W",        {27'h0, RD_W},       {27'h0, e.rd});
                check("PCPlus4W",    PCPlus4W,            e.pcPlus4);
                check("ALU_ResultW", ALU_ResultW,         e.aluResult);
                if (e.readKnown) begin
                    check("ReadDataW", ReadDataW, e.readData);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < TB_DEPTH; i++) begin
            modelMem[i]   = 32'h0;
            modelKnown[i] = 1'b0;
        end

        // Reset with every input nonzero: outputs must be zero before any edge.
        rst         = 1'b0;
        RegWriteM   = 1'b1;
        MemWriteM   = 1'b1;
        ResultSrcM  = 1'b1;
        RD_M        = 5'h1F;
        PCPlus4M    = 32'hFFFF_FFFC;
        WriteDataM  = 32'hFFFF_FFFF;
        ALU_ResultM = 32'h0000_0044;
        #1;
        checkAllZero("reset_initial");
        repeat (2) @(posedge clk);
        @(negedge clk);
        MemWriteM = 1'b0;
        rst       = 1'b1;

        // Store then load.
        store(32'h10, 32'hDEAD_BEEF);
        load(32'h10);

        // Pass-through of control and ALU fields.
        drive(1'b1, 1'b0, 1'b0, 5'd7, 32'h4, 32'h0, 32'h0000_000F);

        // Byte offset ignored, upper address bits wrap.
        store(32'h20, 32'h1234_5678);
        load(32'h23);
        load(32'h20 + TB_DEPTH * 4);

        // Read-before-write on a store, new data on the next load.
        store(32'h40, 32'h1);
        store(32'h40, 32'h2);
        load(32'h40);

        // Reset asserted during a store must block the write.
        store(32'h80, 32'h55);
        @(negedge clk);
        rst         = 1'b0;
        MemWriteM   = 1'b1;
        WriteDataM  = 32'hAA;
        ALU_ResultM = 32'h80;
        RegWriteM   = 1'b1;
        #1;
        checkAllZero("reset_midstore_async");
        @(posedge clk);
        #1;
        checkAllZero("reset_midstore_edge");
        @(negedge clk);
        rst       = 1'b1;
        MemWriteM = 1'b0;
        load(32'h80);

        // Randomized traffic; a narrow address window forces collisions.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] addr;
            addr = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom_range(0, 15) << 2);
            drive(1'($urandom()), 1'($urandom_range(0, 2) == 0), 1'($urandom()), 5'($urandom()),
                  $urandom(), $urandom(), addr);
        end

        @(negedge clk);
        MemWriteM = 1'b0;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", sbq.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have parameter DMEM_DEPTH, default 1024, data memory size in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have port clk  input  1  pipeline clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port RegWriteM  input  1  register-file write enable from Execute stage.
REQ-005 SHALL have port MemWriteM  input  1  data memory store enable.
REQ-006 SHALL have port ResultSrcM  input  1  writeback select (0 = ALU result, 1 = load data).
REQ-007 SHALL have port RD_M  input  5  destination register index.
REQ-008 SHALL have port PCPlus4M  input  32  PC+4 of the instruction in Memory stage.
REQ-009 SHALL have port WriteDataM  input  32  store data (already forwarded).
REQ-010 SHALL have port ALU_ResultM  input  32  ALU result / effective byte address.
REQ-011 SHALL have ports RegWriteW, ResultSrcW  output  1 each  registered copies of RegWriteM, ResultSrcM.
REQ-012 SHALL have port RD_W  output  5  registered RD_M.
REQ-013 SHALL have ports PCPlus4W, ALU_ResultW  output  32 each  registered PCPlus4M, ALU_ResultM.
REQ-014 SHALL have port ReadDataW  output  32  registered load data.

Function
REQ-015 SHALL compute word index = ALU_ResultM[log2(DMEM_DEPTH)+1:2]; bits [1:0] ignored (word-aligned access only, no misalignment trap).
REQ-016 SHALL wrap addresses beyond DMEM_DEPTH*4 modulo memory size (upper address bits ignored, no error).
REQ-017 SHALL read memory combinationally at the word index every cycle, regardless of ResultSrcM.
REQ-018 SHALL write WriteDataM (full 32-bit word) to the word index on rising clk when MemWriteM = 1 and rst = 1.
REQ-019 SHALL, on a cycle with MemWriteM = 1, capture into ReadDataW the old (pre-write) contents of that word (read-before-write).
REQ-020 SHALL register all W outputs on every rising clk with latency exactly 1 cycle; no stall or enable.
REQ-021 SHALL make a load at cycle N+1 to the address stored at cycle N return the new data.
REQ-022 SHALL pass RegWriteM, ResultSrcM, RD_M, PCPlus4M, ALU_ResultM unmodified; no arithmetic performed.
REQ-023 SHALL not gate the write by RegWriteM or ResultSrcM; MemWriteM alone controls stores.

Reset
REQ-024 SHALL, while rst = 0, force RegWriteW=0, ResultSrcW=0, RD_W=5'h00, PCPlus4W, ALU_ResultW, ReadDataW = 32'h0000_0000, asynchronously.
REQ-025 SHALL block memory writes while rst = 0, including a reset asserted in the same cycle as a store.
REQ-026 SHALL NOT clear memory contents on reset; contents are undefined until written (simulation initialises to zero).
REQ-027 SHALL resume normal 1-cycle pipeline operation on the first rising clk after rst deasserts.

Structure
REQ-028 SHALL place DMEM_DEPTH default, data width (32) and register-index width (5) constants in the shared RISC-V pipeline package.
REQ-029 SHALL instantiate one sub-module data_memory (sync write, async read, ports clk, rst, WE, A, WD, RD); pipeline register in memory_cycle.
REQ-030 SHALL contain no latches; the memory array is the only inferred storage outside the W register.

Verification
REQ-031 Reset: rst=0 with all inputs nonzero -> all W outputs 0 immediately, before any clock edge.
REQ-032 Store then load: cycle1 MemWriteM=1, ALU_ResultM=0x10, WriteDataM=0xDEADBEEF; cycle2 MemWriteM=0, ResultSrcM=1, ALU_ResultM=0x10 -> ReadDataW=0xDEADBEEF after cycle2 edge.
REQ-033 Pass-through: RegWriteM=1, RD_M=7, ALU_ResultM=0x0000000F, PCPlus4M=0x4 -> after one edge RegWriteW=1, RD_W=7, ALU_ResultW=0xF, PCPlus4W=0x4.
REQ-034 Alignment/wrap: store 0x12345678 at 0x20; loads from 0x23 and 0x20+DMEM_DEPTH*4 -> both return 0x12345678.
REQ-035 Read-before-write: word 0x40 holds 0x1; store 0x2 to 0x40 -> ReadDataW=0x1 that cycle, 0x2 on next load.
REQ-036 Reset mid-store: rst=0 during MemWriteM=1 to 0x80 with 0xAA -> subsequent load of 0x80 returns prior value, not 0xAA.
